// File: rtl/rr_mux_n_reg.sv
// rr_mux_n_reg: N-way arbitrated mux into a single registered output stage.
// Round-robin or fixed-priority grant, one beat per cycle, back-pressure aware.
module rr_mux_n_reg #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data [0:N-1],
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned SW1 = SELW + 1;

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] start_idx;
  logic [SELW-1:0] scan_idx;
  logic [SW1-1:0]  scan_sum;
  logic [SELW-1:0] grant_idx;
  logic            grant_any;
  logic            accept;
  logic            transfer;

  // Output register can take a new beat when empty or being drained this cycle.
  assign accept   = !out_valid || out_ready;
  assign transfer = accept && grant_any && !reset;

  // Scan requests starting at ptr (round-robin) or at 0 (fixed priority); first hit wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    start_idx = mode ? '0 : ptr;
    for (int k = 0; k < int'(N); k++) begin
      scan_sum = {1'b0, start_idx} + SW1'(k);
      if (scan_sum >= SW1'(N)) begin
        scan_sum = scan_sum - SW1'(N);
      end
      scan_idx = scan_sum[SELW-1:0];
      if (!grant_any && in_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // One-hot ready toward the granted channel only, suppressed during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(N); i++) begin
      in_ready[i] = transfer && (grant_idx == SELW'(i));
    end
  end

  // Output register and round-robin pointer; drain and fill may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx];
      out_sel   <= grant_idx;
      if (!mode) begin
        ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rr_mux_n_reg.md
RR_MUX_N_REG -- requirements
Module: rr_mux_n_reg

Interface
REQ-001 Parameter WIDTH, default 64: width in bits of each data channel.
REQ-002 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default $clog2(N): width of the channel-index signals.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk: input, 1 bit; the single clock; all state updates on its rising edge.
REQ-006 Port reset: input, 1 bit; synchronous, active-high reset.
REQ-007 Port in_data: input, N x WIDTH (unpacked array [0:N-1]); per-channel data.
REQ-008 Port in_valid: input, N bits; bit i high means channel i offers in_data[i].
REQ-009 Port in_ready: output, N bits; bit i high means channel i is accepted this cycle.
REQ-010 Port mode: input, 1 bit; 0 = round-robin arbitration, 1 = fixed priority (index 0 highest).
REQ-011 Port out_data: output, WIDTH bits; registered selected data.
REQ-012 Port out_sel: output, SELW bits; registered index of the channel that supplied out_data.
REQ-013 Port out_valid: output, 1 bit; out_data/out_sel hold a beat.
REQ-014 Port out_ready: input, 1 bit; the consumer accepts the beat when out_valid && out_ready.

Function
REQ-015 The block SHALL hold one output register (data, sel, valid); no other data storage.
REQ-016 accept = !out_valid || out_ready, computed combinationally.
REQ-017 Grant SHALL be combinational and one-hot or zero: at most one in_ready bit high per cycle.
REQ-018 mode=1: grant = lowest index i with in_valid[i].
REQ-019 mode=0: grant = first i with in_valid[i], scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap-around).
REQ-020 in_ready[i] = accept && grant[i] && !reset; transfer on channel i when in_valid[i] && in_ready[i].
REQ-021 On a transfer from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1 at the next edge (latency 1 cycle).
REQ-022 On a transfer in round-robin mode: ptr <= (g == N-1) ? 0 : g+1.
REQ-023 In fixed-priority mode, ptr SHALL NOT change.
REQ-024 When out_valid && out_ready and no input is valid: out_valid <= 0; out_data and out_sel hold their values.
REQ-025 When out_valid && !out_ready: all output registers SHALL hold and in_ready SHALL be all-zero (back-pressure).
REQ-026 Simultaneous drain and fill (out_valid && out_ready && a grant) SHALL load the new beat with no bubble, giving full throughput of 1 beat per cycle.
REQ-027 in_valid SHALL NOT influence outputs except through the grant; in_data of non-granted channels is ignored.
REQ-028 A change of mode SHALL take effect in the same cycle; ptr is retained across mode changes.

Reset
REQ-029 While reset is high at a rising edge, the edge SHALL set out_valid=0, out_data=0, out_sel=0 and ptr=0.
REQ-030 While reset is high, in_ready SHALL be all-zero; no transfer occurs, including mid-stream, and any pending beat is discarded.
REQ-031 The first edge after reset deasserts SHALL be able to accept a transfer.

Verification (N=4, WIDTH=64)
REQ-032 Scenario 1, reset then idle:
- Stimulus: reset for 2 cycles, then in_valid=0000.
- Response: out_valid=0, out_data=0, out_sel=0, in_ready=0000 throughout.
REQ-033 Scenario 2, round-robin fairness:
- Stimulus: mode=0, in_valid=1111 held, in_data[i]=64'hA0+i, out_ready=1.
- Response: out_sel sequence 0,1,2,3,0 on consecutive cycles, with out_data matching each index.
REQ-034 Scenario 3, fixed priority:
- Stimulus: mode=1, in_valid=1110, out_ready=1.
- Response: out_sel=1 every cycle, and in_ready=0010 every cycle.
REQ-035 Scenario 4, back-pressure:
- Stimulus: beat 64'hDEAD from channel 2 registered, then out_ready=0 for 3 cycles with in_valid=1111.
- Response: out_data=64'hDEAD, out_sel=2 and in_ready=0000 for all 3 cycles; on out_ready=1, the next grant is channel 3.
REQ-036 Scenario 5, wrap and sparse requests:
- Stimulus: mode=0, ptr=3 after a grant to channel 2, then in_valid=0011.
- Response: channel 0 granted; then ptr=1 and channel 1 is granted next.
REQ-037 Scenario 6, reset mid-stream:
- Stimulus: assert reset while out_valid=1 and in_valid=1111.
- Response: out_valid=0 the next cycle; after release, the first grant is channel 0 (mode=0).
